// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and decode helper for the registered ALU / mul-div unit.
package alu_pkg;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_NOR   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MULT  = 4'b1010;
  localparam logic [3:0] ALU_MULTU = 4'b1011;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_EQ    = 4'b1101;
  localparam logic [3:0] ALU_DIV   = 4'b1110;
  localparam logic [3:0] ALU_DIVU  = 4'b1111;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  function automatic logic is_muldiv(input logic [3:0] c);
    return (c == ALU_MULT) || (c == ALU_MULTU) || (c == ALU_DIV) || (c == ALU_DIVU);
  endfunction
endpackage

// File: rtl/alu_mdu_if.sv
// Request/result bundle between the EX stage and the ALU / mul-div unit.
interface alu_mdu_if #(parameter int WIDTH = 32);
  localparam int SHW = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [SHW-1:0]   sa;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output in_valid, ctrl, x, y, sa,
                  input  in_ready, out_valid, out, zero, hi, lo);
  modport slave  (input  in_valid, ctrl, x, y, sa,
                  output in_ready, out_valid, out, zero, hi, lo);
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative engine: one bit per cycle shift-add multiply or restoring divide on
// operand magnitudes; hi_o/lo_o carry the sign-corrected result once iteration ends.
module alu_mdu_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d, prod;
  logic [WIDTH-1:0]     opd_q, a_mag, b_mag;
  logic                 div_q, neg_a_q, neg_b_q, bz_q;
  logic                 sgn, is_div;
  logic [WIDTH:0]       sum, diff;

  always_comb begin
    sgn    = (op_i == ALU_MULT) || (op_i == ALU_DIV);
    is_div = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
    a_mag  = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag  = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  // acc = {hi part, lo part}: product grows from the top, quotient bits enter at the bottom
  always_comb begin
    sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : {WIDTH{1'b0}})};
    diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
    if (div_q)
      acc_d = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_d = {sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bz_q    <= 1'b0;
    end else if (start_i) begin
      cnt_q   <= CW'(WIDTH);
      acc_q   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
      opd_q   <= is_div ? b_mag : a_mag;
      div_q   <= is_div;
      neg_a_q <= sgn && a_i[WIDTH-1];
      neg_b_q <= sgn && b_i[WIDTH-1];
      bz_q    <= (b_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      acc_q <= acc_d;
    end
  end

  assign last_o = (cnt_q == CW'(1));

  // Remainder follows the dividend sign; MIN/-1 falls out naturally as {0, MIN}
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    if (div_q) begin
      lo_o = bz_q ? {WIDTH{1'b1}}
                  : ((neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      hi_o = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// Registered integer unit: single-cycle ALU ops plus iterative mul/div writing HI/LO.
module alu_mdu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mdu_if.slave bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] alu_res, it_hi, it_lo;
  logic             ov_q, ov_d, start, last;

  always_comb begin
    case (bus.ctrl)
      ALU_ADD:  alu_res = bus.x + bus.y;
      ALU_SUB:  alu_res = bus.x - bus.y;
      ALU_AND:  alu_res = bus.x & bus.y;
      ALU_OR:   alu_res = bus.x | bus.y;
      ALU_XOR:  alu_res = bus.x ^ bus.y;
      ALU_NOR:  alu_res = ~(bus.x | bus.y);
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.x < bus.y)};
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.x) < $signed(bus.y))};
      ALU_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (bus.x == bus.y)};
      ALU_SLL:  alu_res = bus.y << bus.sa;
      ALU_SRL:  alu_res = bus.y >> bus.sa;
      ALU_SRA:  alu_res = $signed(bus.y) >>> bus.sa;
      default:  alu_res = '0;
    endcase
  end

  alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .op_i    (bus.ctrl),
    .a_i     (bus.x),
    .b_i     (bus.y),
    .last_o  (last),
    .hi_o    (it_hi),
    .lo_o    (it_lo)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ov_d    = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        if (is_muldiv(bus.ctrl)) begin
          start   = 1'b1;
          state_d = RUN;
        end else begin
          out_d = alu_res;
          ov_d  = 1'b1;
        end
      end
      RUN: if (last) state_d = FIN;
      FIN: begin
        hi_d    = it_hi;
        lo_d    = it_lo;
        out_d   = it_lo;
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.out       = out_q;
  assign bus.zero      = (out_q == '0);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Randomized + directed check of alu_mdu against a plain-arithmetic reference model.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] m_out = '0, m_hi = '0, m_lo = '0;

  alu_mdu_if #(.WIDTH(W)) bus();

  alu_mdu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: results from integer arithmetic on the architectural meaning of each op
  task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] s);
    longint sa_l, sb_l, q, r;
    logic [63:0] p, ql, rl;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    case (c)
      ALU_ADD:  m_out = a + b;
      ALU_SUB:  m_out = a - b;
      ALU_AND:  m_out = a & b;
      ALU_OR:   m_out = a | b;
      ALU_XOR:  m_out = a ^ b;
      ALU_NOR:  m_out = ~(a | b);
      ALU_SLTU: m_out = (a < b) ? 1 : 0;
      ALU_SLT:  m_out = (sa_l < sb_l) ? 1 : 0;
      ALU_EQ:   m_out = (a == b) ? 1 : 0;
      ALU_SLL:  m_out = b << s;
      ALU_SRL:  m_out = b >> s;
      ALU_SRA:  m_out = (b >> s) | (b[W-1] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      ALU_MULT, ALU_MULTU: begin
        if (c == ALU_MULT) p = sa_l * sb_l;
        else               p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; m_out = m_lo;
      end
      default: begin
        if (b == 0) begin
          m_lo = '1; m_hi = a;
        end else if (c == ALU_DIV) begin
          q = sa_l / sb_l; r = sa_l % sb_l;
          ql = q; rl = r;
          m_lo = ql[31:0]; m_hi = rl[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        m_out = m_lo;
      end
    endcase
  endtask

  task automatic check_result(input string tag);
    check({tag, "_out"},  bus.out,  m_out);
    check({tag, "_zero"}, bus.zero, (m_out == 0));
    check({tag, "_hi"},   bus.hi,   m_hi);
    check({tag, "_lo"},   bus.lo,   m_lo);
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] s, input bit poke);
    int n;
    bit rdy_bad;
    @(negedge clk);
    check({tag, "_rdy_idle"}, bus.in_ready, 1);
    bus.ctrl = c; bus.x = a; bus.y = b; bus.sa = s; bus.in_valid = 1'b1;
    model(c, a, b, s);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (is_muldiv(c)) begin
      n = 0; rdy_bad = 0;
      // A stray request while busy must be dropped, not queued
      if (poke) begin
        bus.in_valid = 1'b1; bus.ctrl = ALU_ADD; bus.x = 32'h1234; bus.y = 32'h1;
      end
      while (!bus.out_valid && n < 100) begin
        if (bus.in_ready) rdy_bad = 1;
        @(posedge clk); #1;
        n++;
        if (n == 5) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      // out_valid after edge E+W+1: the 34th cycle counting the accept cycle
      check({tag, "_latency"}, n, W + 1);
      check({tag, "_busy_rdy"}, rdy_bad, 0);
      check({tag, "_rdy_back"}, bus.in_ready, 1);
    end else begin
      check({tag, "_valid"}, bus.out_valid, 1);
    end
    check_result(tag);
    @(posedge clk); #1;
    check({tag, "_pulse"}, bus.out_valid, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c;
    logic [W-1:0] a, b;
    logic [4:0] s;
    bus.in_valid = 1'b0; bus.ctrl = '0; bus.x = '0; bus.y = '0; bus.sa = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.in_ready, 1);
    check("rst_valid", bus.out_valid, 0);
    check_result("rst");
    @(negedge clk); rst = 1'b0;

    // back-to-back single-cycle issue
    @(negedge clk);
    bus.ctrl = ALU_ADD; bus.x = 32'd7; bus.y = 32'hFFFF_FFFD; bus.sa = '0; bus.in_valid = 1'b1;
    model(ALU_ADD, 32'd7, 32'hFFFF_FFFD, 5'd0);
    @(posedge clk); #1;
    check("b2b_add_valid", bus.out_valid, 1);
    check_result("b2b_add");
    bus.ctrl = ALU_SUB; bus.x = 32'd5; bus.y = 32'd5;
    model(ALU_SUB, 32'd5, 32'd5, 5'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_sub_valid", bus.out_valid, 1);
    check_result("b2b_sub");

    run_op("sra",   ALU_SRA,   32'h0,         32'h8000_0000, 5'd4, 0);
    run_op("srl",   ALU_SRL,   32'h0,         32'h8000_0000, 5'd4, 0);
    run_op("sltu",  ALU_SLTU,  32'h1,         32'hFFFF_FFFF, 5'd0, 0);
    run_op("slt",   ALU_SLT,   32'h1,         32'hFFFF_FFFF, 5'd0, 0);
    run_op("mult",  ALU_MULT,  32'hFFFF_FFFD, 32'd5,         5'd0, 1);
    run_op("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'd2,         5'd0, 0);
    run_op("div",   ALU_DIV,   32'hFFFF_FFF9, 32'd2,         5'd0, 1);
    run_op("divu",  ALU_DIVU,  32'd100,       32'd7,         5'd0, 0);
    run_op("divov", ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    run_op("div0",  ALU_DIVU,  32'd9,         32'd0,         5'd0, 0);
    run_op("sdiv0", ALU_DIV,   32'hFFFF_FF00, 32'd0,         5'd0, 0);

    // reset in the middle of a divide
    @(negedge clk);
    bus.ctrl = ALU_DIV; bus.x = 32'hFFFF_FF9C; bus.y = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    m_out = '0; m_hi = '0; m_lo = '0;
    check("midrst_ready", bus.in_ready, 1);
    check("midrst_valid", bus.out_valid, 0);
    check_result("midrst");
    @(negedge clk); rst = 1'b0;
    run_op("post_rst_add", ALU_ADD, 32'd2, 32'd2, 5'd0, 0);

    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      s = 5'($urandom_range(0, 31));
      run_op("rand", c, a, b, s, (i % 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the combinational single-cycle ALU. Registered WIDTH-bit integer unit with a valid/ready handshake, adding iterative multiply and divide (signed and unsigned) with HI/LO result registers.
Sits in the EX stage of the pipelined MIPS core. The pipeline stalls on in_ready=0 and takes results on out_valid.

Parameters:
WIDTH, 32, datapath width in bits (power of 2, >=8); SHW = $clog2(WIDTH) is a derived localparam.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operation request
in_ready  out  1  unit can accept an operation this cycle
ctrl  in  4  operation code
x  in  WIDTH  operand A (rs)
y  in  WIDTH  operand B (rt; shifted operand for shifts)
sa  in  SHW  shift amount
out_valid  out  1  one-cycle pulse: out/zero (and hi/lo for mul/div) updated
out  out  WIDTH  registered result
zero  out  1  out == 0
hi  out  WIDTH  HI register (mul high half / remainder)
lo  out  WIDTH  LO register (mul low half / quotient)

Behaviour:
- Reset (async, any state): state=IDLE, out=0, zero=1, out_valid=0, hi=lo=0, in_ready=1. Any in-flight mul/div is discarded.
- Accept: in_valid && in_ready at a rising edge E. in_ready = (state==IDLE).
- ctrl codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sltu, 0101 xor, 0110 nor, 0111 sll, 1000 srl, 1001 sra, 1010 mult, 1011 multu, 1100 slt (signed), 1101 eq, 1110 div, 1111 divu.
- add/sub wrap modulo 2^WIDTH. No overflow flag.
- slt/sltu/eq return 1 or 0, zero-extended.
- Shifts use sa only. sra replicates y[WIDTH-1].
- Single-cycle ops: result is registered at E. out_valid=1 in the cycle after E. State stays IDLE, so back-to-back issue every cycle is allowed.
- Multi-cycle ops (mult/multu/div/divu):
  - IDLE -> RUN at E. Operands are latched as magnitudes plus sign flags for signed ops.
  - RUN iterates one bit per cycle for WIDTH cycles: shift-add multiply or restoring divide.
  - RUN -> FIN for one cycle of sign correction; hi/lo/out are written at that edge.
  - FIN -> IDLE. out_valid=1 in the cycle after edge E+WIDTH+1, i.e. latency WIDTH+2 cycles.
  - in_ready=0 from the cycle after E until the out_valid cycle; in_ready=1 again in the out_valid cycle.
- Mul/div results:
  - mult/multu: {hi,lo} = full 2*WIDTH product; out = lo.
  - div/divu: lo = quotient (truncates toward zero), hi = remainder (sign of dividend); out = lo.
- Divide by zero: lo = all ones, hi = x. Same latency.
- Signed overflow (div, x = -2^(WIDTH-1), y = -1): lo = x, hi = 0.
- in_valid while in_ready=0 is ignored; the requester must hold.
- Single-cycle ops leave hi/lo unchanged. Mul/div leave out unchanged until FIN.
- Undefined ctrl: none remain, since all 16 codes are assigned.
- out_valid is low in every cycle not listed above. out/zero hold their value between updates.

Decomposition:
- Package alu_pkg:
  - 4-bit ctrl code localparams (ALU_ADD ... ALU_DIVU).
  - State encoding IDLE/RUN/FIN.
  - Function is_muldiv(ctrl).
- One sub-module: alu_mdu_iter.
  - Shared iterative shift-add multiplier / restoring divider.
  - Holds the WIDTH-bit counter, the 2*WIDTH accumulator and the sign fix-up.
  - Handshake to parent: start, done.
- The top level holds the single-cycle ops, the FSM, and the out/hi/lo registers.

Test Plan:
- add x=7, y=-3 (0xFFFFFFFD) -> out=4, zero=0, out_valid 1 cycle after accept. Then sub x=y=5 issued the very next cycle -> out=0, zero=1.
- sra y=0x80000000, sa=4 -> out=0xF8000000. srl with the same operands -> 0x08000000. sltu x=1, y=0xFFFFFFFF -> 1. slt with the same operands -> 0.
- mult x=-3, y=5 -> after exactly 34 cycles: hi=0xFFFFFFFF, lo=out=0xFFFFFFF1. in_ready=0 throughout, and a concurrent in_valid is ignored. multu 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- div x=-7, y=2 -> lo=-3 (0xFFFFFFFD), hi=-1. divu x=100, y=7 -> lo=14, hi=2.
- div x=0x80000000, y=-1 -> lo=0x80000000, hi=0. divu x=9, y=0 -> lo=0xFFFFFFFF, hi=9, latency 34.
- Assert rst 10 cycles into a div -> immediately: in_ready=1, out=0, zero=1, hi=lo=0, no out_valid. After release, add 2+2 -> out=4 next cycle.
